// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI memory arbiter.
// The optional statistics counters are enabled with OBI_ARB_STATS_EN.
package obi_arb_pkg;

    localparam int unsigned OBI_NUM_MASTERS = 2;
    localparam int unsigned OBI_ADDR_W      = 32;
    localparam int unsigned OBI_DATA_W      = 32;
    localparam int unsigned OBI_MAX_MASTERS = 16;

    typedef logic [$clog2(OBI_NUM_MASTERS)-1:0] id_t;

    typedef struct packed {
        logic                    req;
        logic [OBI_ADDR_W-1:0]   addr;
        logic                    we;
        logic [OBI_DATA_W/8-1:0] be;
        logic [OBI_DATA_W-1:0]   wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_rsp_t;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // First requesting index at or after ptr, wrapping modulo n; ptr if nobody requests.
    function automatic int unsigned rr_next(input logic [OBI_MAX_MASTERS-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        logic        found;
        rr_next = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < OBI_MAX_MASTERS; i++) begin
            if (!found && (i < n)) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (req[idx]) begin
                    rr_next = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of master IDs for granted-but-unanswered transactions.
// Pointers wrap modulo DEPTH; push is ignored when full, pop when empty.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned ID_W  = $bits(id_t)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [ID_W-1:0] id_i,
    input  logic            pop_i,
    output logic [ID_W-1:0] id_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full_o   = (cnt_q == CNT_W'(DEPTH));
        empty_o  = (cnt_q == '0);
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        id_o     = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= id_i;
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin OBI arbiter sharing one slave port between NUM_MASTERS requesters.
// Define OBI_ARB_STATS_EN to add saturating grant_cnt_o / stall_cnt_o counters.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_MASTERS-1:0]          m_req_i,
    output logic [NUM_MASTERS-1:0]          m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i,
    output logic [NUM_MASTERS-1:0]          m_rvalid_o,
    output logic [DATA_W-1:0]               m_rdata_o,
    output logic                            s_req_o,
    input  logic                            s_gnt_i,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic                            s_we_o,
    output logic [DATA_W/8-1:0]             s_be_o,
    output logic [DATA_W-1:0]               s_wdata_o,
    input  logic                            s_rvalid_i,
    input  logic [DATA_W-1:0]               s_rdata_i,
    output logic                            proto_err_o
`ifdef OBI_ARB_STATS_EN
    ,
    output logic [NUM_MASTERS*32-1:0]       grant_cnt_o,
    output logic [31:0]                     stall_cnt_o
`endif
);

    localparam int unsigned ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_e                 state_q, state_d;
    logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d, locked_id_q, locked_id_d;
    logic [ID_W-1:0]            sel, head_id;
    logic                       proto_err_q, proto_err_d;
    logic                       fifo_full, fifo_empty, hs, pop;
    logic [OBI_MAX_MASTERS-1:0] req_ext;

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .id_i    (sel),
        .pop_i   (pop),
        .id_o    (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        req_ext                  = '0;
        req_ext[NUM_MASTERS-1:0] = m_req_i;
        sel = (state_q == ARB_LOCKED) ? locked_id_q
                                      : ID_W'(rr_next(req_ext, 32'(rr_ptr_q), NUM_MASTERS));

        // Full blocks issue even when a pop lands in the same cycle.
        s_req_o   = m_req_i[sel] & ~fifo_full;
        s_addr_o  = m_addr_i[sel*ADDR_W +: ADDR_W];
        s_we_o    = m_we_i[sel];
        s_be_o    = m_be_i[sel*BE_W +: BE_W];
        s_wdata_o = m_wdata_i[sel*DATA_W +: DATA_W];
        hs        = s_req_o & s_gnt_i;
        m_gnt_o   = '0;
        if (hs) m_gnt_o[sel] = 1'b1;

        pop        = s_rvalid_i & ~fifo_empty;
        m_rvalid_o = '0;
        if (pop) m_rvalid_o[head_id] = 1'b1;
        m_rdata_o  = s_rdata_i;

        rr_ptr_d = rr_ptr_q;
        if (hs) rr_ptr_d = (sel == ID_W'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;

        // A dropped request while locked yields s_req_o=0, which also releases the lock.
        state_d     = (s_req_o & ~s_gnt_i) ? ARB_LOCKED : ARB_FREE;
        locked_id_d = sel;
        proto_err_d = proto_err_q | (s_rvalid_i & fifo_empty);
        proto_err_o = proto_err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_FREE;
            rr_ptr_q    <= '0;
            locked_id_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            locked_id_q <= locked_id_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef OBI_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_MASTERS];
    logic [31:0] stall_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_MASTERS; i++) grant_cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (m_gnt_o[i]) grant_cnt_q[i] <= sat_inc(grant_cnt_q[i]);
            end
            if ((|m_req_i) && !hs) stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) grant_cnt_o[i*32 +: 32] = grant_cnt_q[i];
        stall_cnt_o = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed and randomized bench for obi_mem_arbiter against a queue-based reference model.
// Builds with or without OBI_ARB_STATS_EN.
module tb_obi_mem_arbiter;

    localparam int N    = 2;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  m_req, m_we;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_be;
    logic        s_gnt, s_rvalid;
    logic [31:0] s_rdata;

    logic [1:0]  m_gnt_o, m_rvalid_o;
    logic [31:0] m_rdata_o, s_addr_o, s_wdata_o;
    logic        s_req_o, s_we_o, proto_err_o;
    logic [3:0]  s_be_o;
`ifdef OBI_ARB_STATS_EN
    logic [63:0] grant_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    obi_mem_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MAXO), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .m_req_i     (m_req),
        .m_gnt_o     (m_gnt_o),
        .m_addr_i    (m_addr),
        .m_we_i      (m_we),
        .m_be_i      (m_be),
        .m_wdata_i   (m_wdata),
        .m_rvalid_o  (m_rvalid_o),
        .m_rdata_o   (m_rdata_o),
        .s_req_o     (s_req_o),
        .s_gnt_i     (s_gnt),
        .s_addr_o    (s_addr_o),
        .s_we_o      (s_we_o),
        .s_be_o      (s_be_o),
        .s_wdata_o   (s_wdata_o),
        .s_rvalid_i  (s_rvalid),
        .s_rdata_i   (s_rdata),
        .proto_err_o (proto_err_o)
`ifdef OBI_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt_o),
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding IDs in issue order, round-robin pointer, pending lock.
    int q[$];
    int rr, lid;
    bit locked, perr;
    int gcnt[N];
    int stall;
    int cur_sel;
    bit cur_sreq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_req(input int p);
        for (int i = 0; i < N; i++) if (m_req[(p + i) % N]) return (p + i) % N;
        return p;
    endfunction

    task automatic zero_inputs();
        m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    endtask

    task automatic model_reset();
        q.delete();
        rr = 0; lid = 0; locked = 0; perr = 0; stall = 0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    endtask

    // Compare every output against the model, sampled at the falling edge.
    task automatic eval();
        bit         full, sreq;
        int         sel;
        logic [1:0] eg, erv;
        @(negedge clk);
        full = (q.size() == MAXO);
        sel  = locked ? lid : first_req(rr);
        sreq = m_req[sel] && !full;
        eg   = (sreq && s_gnt) ? 2'(1 << sel) : 2'b00;
        erv  = (s_rvalid && q.size() > 0) ? 2'(1 << q[0]) : 2'b00;
        chk("s_req", s_req_o, sreq);
        chk("m_gnt", m_gnt_o, eg);
        chk("m_rvalid", m_rvalid_o, erv);
        chk("proto_err", proto_err_o, perr);
        if (erv != 2'b00) chk("m_rdata", m_rdata_o, s_rdata);
        if (sreq) begin
            chk("s_addr", s_addr_o, m_addr[sel*32 +: 32]);
            chk("s_we", s_we_o, m_we[sel]);
            chk("s_be", s_be_o, m_be[sel*4 +: 4]);
            chk("s_wdata", s_wdata_o, m_wdata[sel*32 +: 32]);
        end
        cur_sel  = sel;
        cur_sreq = sreq;
    endtask

    task automatic adv();
        bit hs;
        hs = cur_sreq && s_gnt;
        if (s_rvalid) begin
            if (q.size() > 0) void'(q.pop_front());
            else perr = 1;
        end
        if (hs) begin
            q.push_back(cur_sel);
            rr = (cur_sel + 1) % N;
            gcnt[cur_sel]++;
        end
        if ((m_req != 2'b00) && !hs) stall++;
        locked = cur_sreq && !s_gnt;
        lid    = cur_sel;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        eval();
        adv();
    endtask

    task automatic do_reset();
        zero_inputs();
        rst_ni = 1'b0;
        #1;
        chk("rst_s_req", s_req_o, 0);
        chk("rst_m_gnt", m_gnt_o, 0);
        chk("rst_m_rvalid", m_rvalid_o, 0);
        chk("rst_m_rdata", m_rdata_o, 0);
        chk("rst_s_addr", s_addr_o, 0);
        chk("rst_s_we", s_we_o, 0);
        chk("rst_s_be", s_be_o, 0);
        chk("rst_s_wdata", s_wdata_o, 0);
        chk("rst_proto_err", proto_err_o, 0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, n;
        zero_inputs();
        rst_ni = 1'b1;
        model_reset();
        #1;
        do_reset();

        // Single read from master 0, response two cycles later.
        m_req = 2'b01; m_addr[31:0] = 32'h0000_0100; s_gnt = 1'b1;
        eval();
        chk("single_gnt", m_gnt_o, 2'b01);
        adv();
        m_req = 2'b00;
        cycle();
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        eval();
        chk("single_rvalid", m_rvalid_o, 2'b01);
        chk("single_rdata", m_rdata_o, 32'hDEAD_BEEF);
        chk("single_perr", proto_err_o, 0);
        adv();
        s_rvalid = 1'b0;

        // Both masters request continuously with immediate responses.
        c0 = 0; c1 = 0;
        m_req = 2'b11; s_gnt = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_rvalid = (q.size() > 0);
            s_rdata  = $urandom;
            m_addr   = {$urandom, $urandom};
            eval();
            if (m_gnt_o == 2'b01) c0++;
            if (m_gnt_o == 2'b10) c1++;
            adv();
        end
        chk("fair_m0", c0, 50);
        chk("fair_m1", c1, 50);
        m_req = 2'b00;
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            s_rvalid = 1'b1;
            cycle();
        end
        s_rvalid = 1'b0;

        // Master 1 stalled without grant keeps the address phase locked.
        do_reset();
        m_addr = {32'hA1A1_0004, 32'h0B0B_0008};
        m_req = 2'b10; s_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) m_req = 2'b11;
            eval();
            chk("lock_addr", s_addr_o, 32'hA1A1_0004);
            chk("lock_gnt", m_gnt_o, 2'b00);
            adv();
        end
        s_gnt = 1'b1;
        eval();
        chk("lock_first", m_gnt_o, 2'b10);
        adv();
        m_req = 2'b00; s_rvalid = 1'b1;
        eval();
        chk("lock_rsp", m_rvalid_o, 2'b10);
        adv();
        s_rvalid = 1'b0;

        // Fill to MAX_OUTSTANDING, then in-order responses and issue after pop.
        m_req = 2'b11; s_gnt = 1'b1;
        eval(); chk("fill_g0", m_gnt_o, 2'b01); adv();
        eval(); chk("fill_g1", m_gnt_o, 2'b10); adv();
        eval(); chk("full_noreq", s_req_o, 0); adv();
        s_rvalid = 1'b1; s_rdata = 32'h1111_2222;
        eval();
        chk("full_pop_noreq", s_req_o, 0);
        chk("order_first", m_rvalid_o, 2'b01);
        adv();
        s_rvalid = 1'b0;
        eval();
        chk("resume_req", s_req_o, 1);
        chk("resume_gnt", m_gnt_o, 2'b01);
        adv();
        s_rvalid = 1'b1; s_rdata = 32'h3333_4444;
        eval(); chk("order_second", m_rvalid_o, 2'b10); adv();
        m_req = 2'b00;
        eval(); chk("order_third", m_rvalid_o, 2'b01); adv();

        // Response with nothing outstanding.
        eval(); chk("empty_no_rvalid", m_rvalid_o, 2'b00); adv();
        s_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("perr_sticky", proto_err_o, 1);
            adv();
        end

        // Randomized traffic; the slave only responds to outstanding transactions.
        for (int i = 0; i < 400; i++) begin
            m_req    = 2'($urandom);
            m_we     = 2'($urandom);
            m_addr   = {$urandom, $urandom};
            m_wdata  = {$urandom, $urandom};
            m_be     = 8'($urandom);
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata  = $urandom;
            cycle();
        end

        // Reset in the middle of a burst with two transactions in flight.
        s_rvalid = 1'b0;
        m_req = 2'b11; s_gnt = 1'b1;
        for (int i = 0; i < 4 && q.size() < MAXO; i++) cycle();
        chk("burst_inflight", q.size(), MAXO);
        #2;
        do_reset();
        m_req = 2'b01; s_gnt = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            eval();
            if (m_gnt_o == 2'b01) n++;
            adv();
        end
        chk("post_rst_grants", n, MAXO);
        chk("post_rst_perr", proto_err_o, 0);
        m_req = 2'b00; s_rvalid = 1'b1;
        cycle();
        cycle();
        s_rvalid = 1'b0;
        cycle();

`ifdef OBI_ARB_STATS_EN
        chk("stat_grant0", grant_cnt_o[31:0], gcnt[0]);
        chk("stat_grant1", grant_cnt_o[63:32], gcnt[1]);
        chk("stat_stall", stall_cnt_o, stall);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
